// File: rtl/cam_pkg.sv
// Shared types and defaults for the DVP camera capture path.
// State encoding, RGB565 pixel layout and default frame geometry.
package cam_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    SKIP    = 2'd2,
    ACTIVE  = 2'd3
  } cam_state_e;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/cam_byte_pack.sv
// Pairs camera bytes into RGB565 words, MSB byte first.
// Ports: en (byte valid), d (byte), word/word_v (pair), odd (MSB held).
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic       cmos_pclk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] d,
  output rgb565_t    word,
  output logic       word_v,
  output logic       odd
);

  logic [7:0] msb;

  // Phase drops back to 0 whenever bytes stop, so a
  // trailing odd byte is simply forgotten.
  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      odd    <= 1'b0;
      msb    <= '0;
      word   <= '0;
      word_v <= 1'b0;
    end else begin
      word_v <= en & odd;
      if (!en) begin
        odd <= 1'b0;
      end else begin
        odd <= ~odd;
        if (odd) begin
          word <= '{r: msb[7:3],
                    g: {msb[2:0], d[7:5]},
                    b: d[4:0]};
        end else begin
          msb <= d;
        end
      end
    end
  end

endmodule

// File: rtl/cmos_capture.sv
// DVP receive: pixel pairing, x/y tagging, frame strobes, error flags.
// In: cmos_data/href/vsyn, err_clr. Out: pix_*, frame_*, err_*.
module cmos_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int SKIP_FRAMES = 1
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic [7:0]  cmos_data,
  input  logic        cmos_href,
  input  logic        cmos_vsyn,
  input  logic        err_clr,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [10:0] pix_x,
  output logic [9:0]  pix_y,
  output logic        frame_start,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        err_line,
  output logic        err_frame
);

  localparam logic [10:0] H11  = 11'(H_ACTIVE);
  localparam logic [9:0]  V10  = 10'(V_ACTIVE);
  localparam logic [10:0] V11  = 11'(V_ACTIVE);
  localparam logic [9:0]  VMAX = 10'(V_ACTIVE - 1);

  logic [7:0] d_r;
  logic       href_r, href_q;
  logic       vs_r, vs_q;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      d_r    <= '0;
      href_r <= 1'b0;
      href_q <= 1'b0;
      vs_r   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      d_r    <= cmos_data;
      href_r <= cmos_href;
      href_q <= href_r;
      vs_r   <= cmos_vsyn;
      vs_q   <= vs_r;
    end
  end

  logic vs_rise, vs_fall, href_fall;
  assign vs_rise   = vs_r & ~vs_q;
  assign vs_fall   = ~vs_r & vs_q;
  assign href_fall = ~href_r & href_q;

  cam_state_e state_q, state_d;
  logic [3:0] skip_q;
  logic       skip_dec;
  logic       frame_end;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      skip_q  <= 4'(SKIP_FRAMES);
    end else begin
      state_q <= state_d;
      if (skip_dec) skip_q <= skip_q - 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    skip_dec  = 1'b0;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE:
        if (vs_r) state_d = WAIT_VS;
      WAIT_VS:
        if (vs_fall)
          state_d = (skip_q != 4'd0) ? SKIP : ACTIVE;
      SKIP:
        if (vs_rise) begin
          skip_dec = 1'b1;
          state_d  = WAIT_VS;
        end
      ACTIVE:
        if (vs_rise) begin
          frame_end = 1'b1;
          state_d   = WAIT_VS;
        end
      default:
        state_d = IDLE;
    endcase
  end

  logic    active, pack_en, line_end;
  rgb565_t word;
  logic    word_v, odd;

  assign active   = (state_q == ACTIVE);
  // A vsync rise mid-line kills the byte on that edge.
  assign pack_en  = active & href_r & ~vs_rise;
  assign line_end = active & href_fall;

  cam_byte_pack u_pack (
    .cmos_pclk (cmos_pclk),
    .rst_n     (rst_n),
    .en        (pack_en),
    .d         (d_r),
    .word      (word),
    .word_v    (word_v),
    .odd       (odd)
  );

  logic [11:0] byte_cnt;
  logic [9:0]  line_cnt;
  logic [10:0] col;
  logic        has_pix, keep;
  logic        line_bad, frame_bad;
  logic [10:0] lines_eff;

  assign col      = byte_cnt[11:1];
  assign has_pix  = (col != 11'd0);
  assign keep     = (col < H11) && (line_cnt < V10);
  assign line_bad = line_end & (odd | (col != H11));

  // A line ending on the same edge as vsync still counts.
  assign lines_eff = {1'b0, line_cnt}
                   + 11'(line_end & has_pix);
  assign frame_bad = frame_end
                   & (href_r | (lines_eff != V11));

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      line_cnt <= '0;
    end else begin
      if (!pack_en)
        byte_cnt <= '0;
      else if (byte_cnt != 12'hFFF)
        byte_cnt <= byte_cnt + 12'd1;
      if (vs_fall)
        line_cnt <= '0;
      else if (line_end && has_pix
               && line_cnt != 10'h3FF)
        line_cnt <= line_cnt + 10'd1;
    end
  end

  logic [10:0] tag_x;
  logic [9:0]  tag_y;
  logic        keep_r, emit;

  assign emit = word_v & keep_r;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      tag_x  <= '0;
      tag_y  <= '0;
      keep_r <= 1'b0;
    end else begin
      keep_r <= 1'b0;
      if (pack_en && odd) begin
        tag_x  <= col;
        tag_y  <= (line_cnt > VMAX) ? VMAX : line_cnt;
        keep_r <= keep;
      end
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      err_line    <= 1'b0;
      err_frame   <= 1'b0;
    end else begin
      pix_valid   <= emit;
      frame_start <= emit && tag_x == 11'd0
                          && tag_y == 10'd0;
      if (emit) begin
        pix_data <= word;
        pix_x    <= tag_x;
        pix_y    <= tag_y;
      end
      frame_done <= frame_end;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      if (line_bad)     err_line <= 1'b1;
      else if (err_clr) err_line <= 1'b0;
      if (frame_bad)    err_frame <= 1'b1;
      else if (err_clr) err_frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmos_capture.sv
// Randomized directed bench for cmos_capture at reduced geometry.
// Frame-level reference model predicts pixels, strobes and flags.
module tb_cmos_capture;

  localparam int H  = 8;
  localparam int V  = 6;
  localparam int SK = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  cmos_data = '0;
  logic        cmos_href = 1'b0;
  logic        cmos_vsyn = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [9:0]  pix_y;
  logic        frame_start, frame_done;
  logic [15:0] frame_cnt;
  logic        err_line, err_frame;

  cmos_capture #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .SKIP_FRAMES (SK)
  ) dut (
    .cmos_pclk   (clk),
    .rst_n       (rst_n),
    .cmos_data   (cmos_data),
    .cmos_href   (cmos_href),
    .cmos_vsyn   (cmos_vsyn),
    .err_clr     (err_clr),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt),
    .err_line    (err_line),
    .err_frame   (err_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int nassert = 0;
  int nfail = 0;
  int cyc = 0;
  int done_seen = 0;

  int  skip_left = SK;
  bit  cur_cap = 0;
  int  cur_lines = 0;
  int  exp_done = 0;
  int  exp_fc = 0;
  bit  exp_el = 0;
  bit  exp_ef = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    nassert++;
    assert (obs === want) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_done === 1'b1) done_seen++;
      if (pix_valid === 1'b1) begin
        chk("pix_expected", 32'(q.size() > 0), 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("pix_data", pix_data, e.d);
          chk("pix_x", pix_x, e.x);
          chk("pix_y", pix_y, e.y);
          chk("pix_latency", cyc, e.cyc);
          chk("frame_start", frame_start,
              32'(e.x == 0 && e.y == 0));
        end
      end else begin
        chk("fs_stray", frame_start, 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_x", pix_x, 0);
    chk("rst_pix_y", pix_y, 0);
    chk("rst_fstart", frame_start, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_err_line", err_line, 0);
    chk("rst_err_frame", err_frame, 0);
    chk("rst_inflight", q.size(), 0);
    skip_left = SK;
    cur_cap   = 0;
    exp_fc    = 0;
    exp_el    = 0;
    exp_ef    = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic line(input int nb, input bit pat,
                      input int ab);
    logic [7:0] b;
    logic [7:0] msb;
    int ly;
    ly  = cur_lines;
    msb = '0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      if (pat)
        b = (i % 2 == 0) ? 8'h80 : 8'(i / 2);
      else
        b = 8'($urandom);
      cmos_data = b;
      if (i == ab) cmos_vsyn = 1'b1;
      if (ab >= 0 && i >= ab) continue;
      if (i % 2 == 0)
        msb = b;
      else if (cur_cap && i / 2 < H && ly < V)
        q.push_back('{d: {msb, b}, x: i / 2,
                      y: ly, cyc: cyc + 3});
    end
    @(negedge clk);
    cmos_href = 1'b0;
    repeat (3) @(negedge clk);
    if (cur_cap) begin
      if (ab >= 0) begin
        exp_done++;
        exp_fc++;
        exp_ef  = 1;
        cur_cap = 0;
      end else begin
        if (nb != 2 * H) exp_el = 1;
        if (nb >= 2) cur_lines++;
      end
    end
  endtask

  task automatic frame(input bit pat, input int nl,
                       input int bl, input int bb,
                       input int al, input int ab,
                       input int rl);
    @(negedge clk);
    cmos_vsyn = 1'b1;
    cmos_href = 1'b0;
    if (cur_cap) begin
      exp_done++;
      exp_fc++;
      if (cur_lines != V) exp_ef = 1;
    end
    if (skip_left > 0) begin
      cur_cap = 0;
      skip_left--;
    end else begin
      cur_cap = 1;
    end
    cur_lines = 0;
    repeat (5) @(negedge clk);
    cmos_vsyn = 1'b0;
    repeat (4) @(negedge clk);
    for (int l = 0; l < nl; l++) begin
      if (l == rl) do_reset();
      line((l == bl) ? bb : 2 * H, pat,
           (l == al) ? ab : -1);
      if (l == al) break;
    end
  endtask

  task automatic status(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_err_line"}, err_line, exp_el);
    chk({tag, "_err_frame"}, err_frame, exp_ef);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_fc);
    chk({tag, "_done"}, done_seen, exp_done);
    chk({tag, "_drained"}, q.size(), 0);
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_el = 0;
    exp_ef = 0;
  endtask

  initial begin
    do_reset();
    line(2 * H, 0, -1);
    line(2 * H + 3, 0, -1);
    status("pre");
    frame(0, V, -1, 0, -1, 0, -1);
    status("skip");
    frame(1, V, -1, 0, -1, 0, -1);
    status("pattern");
    frame(0, V, -1, 0, -1, 0, -1);
    status("random");
    frame(0, V, 5, 2 * H - 2, -1, 0, -1);
    status("short");
    clear_err();
    status("clr1");
    frame(0, V, 2, 2 * H + 1, -1, 0, -1);
    status("long");
    clear_err();
    frame(0, V + 1, -1, 0, -1, 0, -1);
    status("extra");
    frame(0, V, -1, 0, 3, 5, -1);
    status("abort");
    clear_err();
    status("clr2");
    frame(0, V, -1, 0, -1, 0, -1);
    status("after_abort");
    frame(0, V, -1, 0, -1, 0, 2);
    status("rst_mid");
    frame(0, V, -1, 0, -1, 0, -1);
    status("resync_skip");
    frame(0, V, -1, 0, -1, 0, -1);
    status("resync_cap");
    frame(0, 0, -1, 0, -1, 0, -1);
    status("final");
    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
